// File: rtl/approx_err_monitor.sv
// Purpose: rebuilds the exact sum behind a 32-bit approximate adder and collects per-window error statistics.
// Latency: 3 clk from an accepted sample to the statistics; done rises 3 clk after the window's last accept.
// Backpressure: in_ready is high only while a window is running; there is no buffering beyond the 2-stage pipe.
module approx_err_monitor #(
  parameter int WIDTH  = 32,
  parameter int N_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [WIDTH:0]             approx_sum,
  output logic                       busy,
  output logic                       done,
  output logic [N_LOG2:0]            err_count,
  output logic [WIDTH+N_LOG2:0]      sum_ed,
  output logic [WIDTH:0]             max_ed
);

  localparam int SW   = WIDTH + 1;
  localparam int CW   = N_LOG2 + 1;
  localparam int SUMW = WIDTH + 1 + N_LOG2;

  localparam logic [N_LOG2-1:0] CNT_ONE = N_LOG2'(1);
  localparam logic [CW-1:0]     ERR_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sample held in the first pipe stage: the recomputed exact sum next to the adder's answer.
  typedef struct packed {
    logic [SW-1:0] exact;
    logic [SW-1:0] approx;
  } s1_dat_t;

  state_t            state;
  logic [N_LOG2-1:0] smp_cnt;

  logic              s1_vld;
  s1_dat_t           s1_dat;
  logic              s2_vld;
  logic [SW-1:0]     s2_ed;

  logic              accept;
  logic              last_accept;
  logic              start_ok;
  logic              pipe_empty;
  logic [SW-1:0]     exact_nxt;
  logic [SW-1:0]     ed_nxt;
  logic              ed_nz;

  // A window is complete once the counter has wrapped through every slot; start only counts when idle/done.
  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (smp_cnt == '1);
  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign pipe_empty  = !s1_vld && !s2_vld;
  assign exact_nxt   = {1'b0, a} + {1'b0, b};
  assign ed_nz       = |s2_ed;

  // Unsigned error distance between the exact and approximate sums held in stage 1.
  always_comb begin
    ed_nxt = '0;
    if (s1_dat.exact >= s1_dat.approx) begin
      ed_nxt = s1_dat.exact - s1_dat.approx;
    end else begin
      ed_nxt = s1_dat.approx - s1_dat.exact;
    end
  end

  // Window control FSM; in_ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN: begin
          if (last_accept) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Accepted-sample counter; restarted whenever a new window is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= '0;
    end else if (start_ok) begin
      smp_cnt <= '0;
    end else if (accept) begin
      smp_cnt <= smp_cnt + CNT_ONE;
    end
  end

  // Stage 1: capture the exact sum and the approximate sum for each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_dat.exact  <= exact_nxt;
        s1_dat.approx <= approx_sum;
      end
    end
  end

  // Stage 2: register the error distance; bubbles leave the data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_ed  <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_ed <= ed_nxt;
      end
    end
  end

  // Statistics accumulate live from stage 2 and hold once the window is done until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (start_ok) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (s2_vld) begin
      if (ed_nz) begin
        err_count <= err_count + ERR_ONE;
      end
      sum_ed <= sum_ed + SUMW'(s2_ed);
      if (s2_ed > max_ed) begin
        max_ed <= s2_ed;
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Purpose: scoreboard bench for approx_err_monitor with a small window (4 samples).
// Latency: expected window results are queued as samples are accepted and checked when done rises.
// Backpressure: the driver holds each sample until in_ready accepts it, with bounded waits.
module tb_approx_err_monitor;

  localparam int W   = 32;
  localparam int NL  = 2;
  localparam int WIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W:0]    approx_sum = '0;
  logic          busy;
  logic          done;
  logic [NL:0]   err_count;
  logic [W+NL:0] sum_ed;
  logic [W:0]    max_ed;

  approx_err_monitor #(.WIDTH(W), .N_LOG2(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned ec;
    longint unsigned sum;
    longint unsigned mx;
    longint unsigned cyc;
  } exp_t;

  exp_t            exp_q[$];
  longint unsigned win_q[$];
  exp_t            e_new;
  exp_t            last_exp;
  longint unsigned cyc = 0;
  int              acc_total = 0;
  int              n_cmp = 0;
  int              n_mis = 0;
  logic            done_q = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endfunction

  // Reference error distance: |(a+b) - approx| on plain 64-bit integers.
  function automatic longint unsigned ref_ed(input longint unsigned aa, input longint unsigned bb,
                                             input longint unsigned ss);
    longint unsigned ex;
    ex = aa + bb;
    return (ex >= ss) ? (ex - ss) : (ss - ex);
  endfunction

  // Accept monitor: every WIN accepted samples form one window whose statistics are queued.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      win_q.delete();
    end else if (in_valid && in_ready) begin
      acc_total++;
      win_q.push_back(ref_ed(longint'(a), longint'(b), longint'(approx_sum)));
      if (win_q.size() == WIN) begin
        e_new.ec  = 0;
        e_new.sum = 0;
        e_new.mx  = 0;
        foreach (win_q[i]) begin
          if (win_q[i] != 0) e_new.ec++;
          e_new.sum += win_q[i];
          if (win_q[i] > e_new.mx) e_new.mx = win_q[i];
        end
        e_new.cyc = cyc;
        exp_q.push_back(e_new);
        win_q.delete();
      end
    end
  end

  // Output monitor: on each rising done, compare statistics and the accept-to-done latency.
  always @(negedge clk) begin
    if (rst_n && done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        chk("err_count", 64'(err_count), last_exp.ec);
        chk("sum_ed", 64'(sum_ed), last_exp.sum);
        chk("max_ed", 64'(max_ed), last_exp.mx);
        chk("done_latency", cyc - last_exp.cyc, 64'd3);
      end
    end
    done_q = done;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one sample and hold it until accepted; optional bubble cycles afterwards.
  task automatic drive(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W:0] si,
                       input int max_bub);
    int t;
    t = 0;
    in_valid   = 1'b1;
    a          = ai;
    b          = bi;
    approx_sum = si;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      @(negedge clk);
    end
    in_valid   = 1'b0;
    a          = $urandom;
    b          = $urandom;
    approx_sum = {1'($urandom), 32'($urandom)};
    if (max_bub > 0) repeat ($urandom_range(0, max_bub)) @(negedge clk);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  // Random operands with an approx_sum that is exact, OR-lower approximate, nearby or arbitrary.
  task automatic drive_rand(input int max_bub);
    logic [W-1:0]    ai, bi;
    logic [W:0]      si;
    longint unsigned ex, up, lo;
    int              k;
    ai = $urandom;
    bi = $urandom;
    ex = longint'(ai) + longint'(bi);
    case ($urandom_range(0, 3))
      0: si = ex[W:0];
      1: begin
        k  = $urandom_range(1, 16);
        up = ((longint'(ai) >> k) + (longint'(bi) >> k)) << k;
        lo = longint'(ai | bi) & ((64'd1 << k) - 1);
        si = 33'(up | lo);
      end
      2: si = ex[W:0] ^ 33'($urandom_range(1, 255));
      default: si = {1'($urandom), 32'($urandom)};
    endcase
    drive(ai, bi, si, max_bub);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_sum_ed", 64'(sum_ed), 64'd0);
    chk("rst_max_ed", 64'(max_ed), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Asynchronous reset in the middle of a window
    pulse_start();
    drive(32'd1, 32'd1, 33'd1, 0);
    drive(32'd1, 32'd1, 33'd1, 0);
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_err_count", 64'(err_count), 64'd2);
    chk("mid_sum_ed", 64'(sum_ed), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    chk("arst_sum_ed", 64'(sum_ed), 64'd0);
    chk("arst_max_ed", 64'(max_ed), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle", 64'(in_ready), 64'd0);

    // Every sample off by one
    pulse_start();
    repeat (WIN) drive(32'd1, 32'd1, 33'd1, 0);
    wait_done();
    chk("t2_err_count", 64'(err_count), 64'd4);
    chk("t2_sum_ed", 64'(sum_ed), 64'd4);
    chk("t2_max_ed", 64'(max_ed), 64'd1);

    // Exact results only
    pulse_start();
    repeat (WIN) drive(32'h8000, 32'h8000, 33'h10000, 1);
    wait_done();
    chk("t3_err_count", 64'(err_count), 64'd0);
    chk("t3_sum_ed", 64'(sum_ed), 64'd0);
    chk("t3_max_ed", 64'(max_ed), 64'd0);

    // Mixed window including a carry-out sample
    pulse_start();
    drive(32'hFFFF_FFFF, 32'd1, 33'h0_FFFF_FFFF, 0);
    drive(32'h7FFF, 32'h7FFF, 33'h7FFF, 0);
    drive(32'h10, 32'h20, 33'h30, 0);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 0);
    wait_done();
    chk("t4_err_count", 64'(err_count), 64'd2);
    chk("t4_sum_ed", 64'(sum_ed), 64'h8000);
    chk("t4_max_ed", 64'(max_ed), 64'h7FFF);

    // Bubbles, then a fifth sample that must not be taken
    pulse_start();
    repeat (WIN) drive_rand(3);
    acc0       = acc_total;
    in_valid   = 1'b1;
    a          = 32'd5;
    b          = 32'd6;
    approx_sum = 33'd0;
    repeat (8) @(negedge clk);
    chk("t5_no_extra_accept", 64'(acc_total - acc0), 64'd0);
    chk("t5_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done();

    // start during RUN is ignored; start in DONE clears and restarts
    pulse_start();
    drive_rand(1);
    drive_rand(1);
    pulse_start();
    drive_rand(1);
    drive_rand(1);
    wait_done();
    repeat (5) @(negedge clk);
    chk("t6_hold_sum", 64'(sum_ed), last_exp.sum);
    chk("t6_hold_cnt", 64'(err_count), last_exp.ec);
    pulse_start();
    chk("t6_clr_err_count", 64'(err_count), 64'd0);
    chk("t6_clr_sum_ed", 64'(sum_ed), 64'd0);
    chk("t6_clr_max_ed", 64'(max_ed), 64'd0);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_done_low", 64'(done), 64'd0);
    repeat (WIN) drive_rand(2);
    wait_done();

    // Random windows
    for (int w = 0; w < 8; w++) begin
      pulse_start();
      repeat (WIN) drive_rand(2);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
